// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B.
// One full-subtractor cell plus a borrow flop processes one bit per clock,
// LSB first. Operands enter on a valid/ready handshake and the result leaves
// on a valid/ready handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf_o.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, diff}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    logic diff;
    logic br_out;
    diff   = a ^ b ^ br;
    br_out = (~a & b) | (~(a ^ b) & br);
    return {br_out, diff};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bo_q, bo_d;
  logic [1:0]       cell_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    dout_d  = dout_q;
    bo_d    = bo_q;
    cell_s  = full_sub(a_q[0], b_q[0], br_q);
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
`endif
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {cell_s[0], res_q[WIDTH-1:1]};
        br_d  = cell_s[1];
        if (cnt_q == LAST_CNT) begin
          // The bit just produced is the result MSB; publish the full word.
          dout_d  = {cell_s[0], res_q[WIDTH-1:1]};
          bo_d    = cell_s[1];
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) & (cell_s[0] != a_msb_q);
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      dout_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      dout_q  <= dout_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_RUN);
  assign out_valid_o = (state_q == ST_DONE);
  assign d_o         = dout_q;
  assign bo_o        = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor
// (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         ovf;
  int           n_cmp;
  int           n_fail;
  int           cyc;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .d_o        (d),
    .bo_o       (bo),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_o      (ovf),
`endif
    .busy_o     (busy)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so accept spacing can be measured.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y);
    int diff;
    diff = int'(x) - int'(y) + 256;
    return W'(diff % 256);
  endfunction

  function automatic logic ref_bo(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    return (sd > 127) || (sd < -128);
  endfunction

  // Performs one operation from IDLE; caller is at a negedge.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
    int lat;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; a = xa; b = xb; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== W) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, W);
    end
    n_cmp++;
    if (d !== ref_d(xa, xb) || bo !== ref_bo(xa, xb)) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h: got d=%h bo=%b want d=%h bo=%b",
               tag, xa, xb, d, bo, ref_d(xa, xb), ref_bo(xa, xb));
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (ovf !== ref_ovf(xa, xb)) begin
      n_fail++;
      $display("FAIL %s ovf a=%h b=%h: got %b want %b", tag, xa, xb, ovf, ref_ovf(xa, xb));
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== ref_d(xa, xb)) begin
      n_fail++;
      $display("FAIL %s after handshake: got in_ready=%b out_valid=%b d=%h want 1 0 %h",
               tag, in_ready, out_valid, d, ref_d(xa, xb));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        d !== 8'h00 || bo !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state: got rdy=%b busy=%b vld=%b d=%h bo=%b ovf=%b want 1 0 0 00 0 0",
               in_ready, busy, out_valid, d, bo, ovf);
    end
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, "basic");
  endtask

  task automatic test_borrow();
    run_op(8'h03, 8'h05, "borrow_03_05");
    run_op(8'h00, 8'h01, "borrow_00_01");
    run_op(8'h00, 8'h00, "zero");
    run_op(8'hFF, 8'h00, "ff_00");
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int lat;
    in_valid = 1'b1; a = 8'h3C; b = 8'h5A; out_ready = 1'b0;
    @(negedge clk);
    a = 8'h11; b = 8'h22;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    held = ref_d(8'h3C, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== held || bo !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: got vld=%b rdy=%b d=%h bo=%b want 1 0 %h 1",
                 k, out_valid, in_ready, d, bo, held);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || d !== held) begin
      n_fail++;
      $display("FAIL backpressure release: got rdy=%b vld=%b busy=%b d=%h want 1 0 0 %h",
               in_ready, out_valid, busy, d, held);
    end
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1'b1; a = 8'h55; b = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun busy before reset: got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun after reset: got busy=%b vld=%b rdy=%b want 0 0 1",
               busy, out_valid, in_ready);
    end
    run_op(8'hA0, 8'h0A, "after_reset");
  endtask

  task automatic test_back_to_back();
    int t1, t2, k;
    logic got1;
    in_valid = 1'b1; a = 8'h10; b = 8'h20; out_ready = 1'b1;
    t1 = cyc;
    t2 = -1;
    got1 = 1'b0;
    @(negedge clk);
    a = 8'hC8; b = 8'h37;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid && !got1) begin
        got1 = 1'b1;
        n_cmp++;
        if (d !== ref_d(8'h10, 8'h20) || bo !== ref_bo(8'h10, 8'h20)) begin
          n_fail++;
          $display("FAIL b2b first: got d=%h bo=%b want %h %b", d, bo,
                   ref_d(8'h10, 8'h20), ref_bo(8'h10, 8'h20));
        end
      end
      if (in_ready) begin
        t2 = cyc;
        break;
      end
    end
    n_cmp++;
    if (!got1 || t2 - t1 !== W + 2) begin
      n_fail++;
      $display("FAIL b2b spacing: got %0d (first seen %b) want %0d", t2 - t1, got1, W + 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || d !== ref_d(8'hC8, 8'h37) || bo !== ref_bo(8'hC8, 8'h37)) begin
      n_fail++;
      $display("FAIL b2b second: got vld=%b d=%h bo=%b want 1 %h %b", out_valid, d, bo,
               ref_d(8'hC8, 8'h37), ref_bo(8'hC8, 8'h37));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_ovf();
    run_op(8'h80, 8'h01, "ovf_80_01");
    run_op(8'h7F, 8'hFF, "ovf_7f_ff");
    run_op(8'h05, 8'h03, "ovf_05_03");
    run_op(8'h7F, 8'h80, "ovf_7f_80");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
